// File: rtl/mult_hilo_seq.sv
// -----------------------------------------------------------------------------
// mult_hilo_seq
// Multi-cycle MULT/MULTU engine for the EX stage. A radix-2 shift-add datapath
// forms the unsigned product of the operand magnitudes over WIDTH cycles. A
// final FIX cycle applies the sign. The block owns the architectural HI/LO
// registers and raises the pipeline stall that interlocks a new multiply or an
// MFHI/MFLO against an operation still in flight.
//
// Ports
//   clk        in   pipeline clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   EX holds a MULT/MULTU this cycle
//   is_signed  in   1 = MULT (two's complement), 0 = MULTU
//   op_a       in   rs operand (multiplicand), after forwarding
//   op_b       in   rt operand (multiplier), after forwarding
//   hilo_read  in   ID holds MFHI/MFLO this cycle
//   flush      in   squash EX (branch/jump redirect)
//   stall      out  freeze IF/ID/EX, bubble into MEM
//   busy       out  operation in RUN or FIX
//   done       out  one-cycle pulse, HI/LO updated at the preceding edge
//   hi         out  HI register
//   lo         out  LO register
// -----------------------------------------------------------------------------
module mult_hilo_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             hilo_read,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic                 accept;
   logic [WIDTH-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic                 neg_q, neg_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [WIDTH:0]       addend;
   logic [WIDTH:0]       sum;

   // Magnitude of a possibly signed operand. The most negative value maps onto
   // itself and is then treated as an unsigned magnitude of 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                  input logic                    sgn);
      logic signed [WIDTH-1:0] n;
      n = -v;
      return (sgn && v[WIDTH-1]) ? n : v;
   endfunction

   // Restore the sign of the unsigned magnitude product.
   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                     input logic               neg);
      return neg ? (~p + (2*WIDTH)'(1)) : p;
   endfunction

   assign accept = start & ~flush & ((state_q == S_IDLE) | (state_q == S_DONE));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_RUN;
         S_RUN: begin
            if (flush)                            state_d = S_IDLE;
            else if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
         end
         S_FIX:  state_d = flush ? S_IDLE : S_DONE;
         S_DONE: state_d = accept ? S_RUN : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy  = (state_q == S_RUN) | (state_q == S_FIX);
      done  = (state_q == S_DONE);
      stall = busy & (start | hilo_read);
   end

   // Shift-add datapath next state
   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      neg_d    = neg_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      addend   = mplier_q[0] ? {1'b0, mcand_q} : '0;
      sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;

      if (accept) begin
         mcand_d  = magnitude(op_a, is_signed);
         mplier_d = magnitude(op_b, is_signed);
         neg_d    = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
         acc_d    = '0;
         cnt_d    = '0;
      end else if (state_q == S_RUN && !flush) begin
         // {carry, accumulator, multiplier} >> 1
         acc_d    = {sum, acc_q[WIDTH-1:1]};
         mplier_d = {acc_q[0], mplier_q[WIDTH-1:1]};
         cnt_d    = cnt_q + CNT_W'(1);
      end else if (state_q == S_FIX && !flush) begin
         {hi_d, lo_d} = apply_sign(acc_q, neg_q);
      end
   end

   // Accumulator, counter and HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
      end
   end

   // Operand capture; only meaningful while the FSM is in RUN or FIX
   always_ff @(posedge clk) begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_mult_hilo_seq.sv
module tb_mult_hilo_seq;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         is_signed;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         hilo_read;
   logic         flush;
   logic         stall;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   mult_hilo_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .is_signed (is_signed),
      .op_a      (op_a),
      .op_b      (op_b),
      .hilo_read (hilo_read),
      .flush     (flush),
      .stall     (stall),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one multiply from cycle 0, wait (bounded) for done.
   // Returns the done cycle number, busy-cycle count and HI/LO seen in it.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output int lat, output int bcnt,
                         output logic [W-1:0] h, output logic [W-1:0] l);
      start = 1'b1; is_signed = s; op_a = a; op_b = b;
      next_cycle();
      start = 1'b0; op_a = '0; op_b = '0;
      lat = 1; bcnt = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) bcnt++;
         next_cycle();
         lat++;
      end
      h = hi; l = lo;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; hilo_read = 1'b1; flush = 1'b0;
      is_signed = 1'b0; op_a = 32'd5; op_b = 32'd5;
      repeat (2) @(posedge clk);
      #2;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done: got %b want 0", done); end
      vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %b want 0", stall); end
      vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL reset_hi: got %h want 00000000", hi); end
      vec_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL reset_lo: got %h want 00000000", lo); end
      start = 1'b0; hilo_read = 1'b0; op_a = '0; op_b = '0;
      #1 rst_n = 1'b1;
      next_cycle();
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL post_reset_busy: got %b want 0", busy); end
   endtask

   task automatic test_unsigned();
      int lat, bcnt;
      logic [W-1:0] h, l;
      run_op(32'd7, 32'd6, 1'b0, lat, bcnt, h, l);
      vec_cnt++; if (lat != 34) begin err_cnt++; $display("FAIL u7x6_latency: got %0d want 34", lat); end
      vec_cnt++; if (bcnt != 33) begin err_cnt++; $display("FAIL u7x6_busy_cycles: got %0d want 33", bcnt); end
      vec_cnt++; if (h !== 32'h0) begin err_cnt++; $display("FAIL u7x6_hi: got %h want 00000000", h); end
      vec_cnt++; if (l !== 32'h2A) begin err_cnt++; $display("FAIL u7x6_lo: got %h want 0000002a", l); end
      next_cycle();
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL u7x6_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_unsigned_max();
      logic [W-1:0] ta [2] = '{32'hFFFF_FFFF, 32'h8000_0000};
      logic [W-1:0] tb [2] = '{32'hFFFF_FFFF, 32'h0000_0002};
      logic [W-1:0] eh [2] = '{32'hFFFF_FFFE, 32'h0000_0001};
      logic [W-1:0] el [2] = '{32'h0000_0001, 32'h0000_0000};
      int lat, bcnt;
      logic [W-1:0] h, l;
      for (int i = 0; i < 2; i++) begin
         run_op(ta[i], tb[i], 1'b0, lat, bcnt, h, l);
         vec_cnt++; if (h !== eh[i]) begin err_cnt++; $display("FAIL umax%0d_hi: got %h want %h", i, h, eh[i]); end
         vec_cnt++; if (l !== el[i]) begin err_cnt++; $display("FAIL umax%0d_lo: got %h want %h", i, l, el[i]); end
         next_cycle();
      end
   endtask

   task automatic test_signed();
      logic [W-1:0] ta [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
      logic [W-1:0] tb [4] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0001};
      logic [W-1:0] eh [4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h4000_0000, 32'hFFFF_FFFF};
      logic [W-1:0] el [4] = '{32'hFFFF_FFF1, 32'h0000_0001, 32'h0000_0000, 32'h8000_0000};
      int lat, bcnt;
      logic [W-1:0] h, l;
      for (int i = 0; i < 4; i++) begin
         run_op(ta[i], tb[i], 1'b1, lat, bcnt, h, l);
         vec_cnt++; if (h !== eh[i]) begin err_cnt++; $display("FAIL signed%0d_hi: got %h want %h", i, h, eh[i]); end
         vec_cnt++; if (l !== el[i]) begin err_cnt++; $display("FAIL signed%0d_lo: got %h want %h", i, l, el[i]); end
         next_cycle();
      end
   endtask

   task automatic test_hilo_interlock();
      logic exp;
      start = 1'b1; is_signed = 1'b0; op_a = 32'h1234_5678; op_b = 32'h0000_0010;
      next_cycle();
      start = 1'b0; op_a = '0; op_b = '0;
      for (int cyc = 1; cyc <= 34; cyc++) begin
         hilo_read = (cyc >= 5);
         #1;
         exp = (cyc >= 5) && (cyc <= 33);
         vec_cnt++; if (stall !== exp) begin err_cnt++; $display("FAIL mfhi_stall_c%0d: got %b want %b", cyc, stall, exp); end
         if (cyc == 34) begin
            vec_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL mfhi_done: got %b want 1", done); end
            vec_cnt++; if (hi !== 32'h0000_0001) begin err_cnt++; $display("FAIL mfhi_hi: got %h want 00000001", hi); end
            vec_cnt++; if (lo !== 32'h2345_6780) begin err_cnt++; $display("FAIL mfhi_lo: got %h want 23456780", lo); end
         end else begin
            next_cycle();
         end
      end
      hilo_read = 1'b0;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      int cyc;
      start = 1'b1; is_signed = 1'b0; op_a = 32'd3; op_b = 32'd4;
      next_cycle();
      is_signed = 1'b1; op_a = 32'hFFFF_FFFE; op_b = 32'd7;
      for (int c = 1; c <= 34; c++) begin
         #1;
         vec_cnt++; if (stall !== (c <= 33)) begin err_cnt++; $display("FAIL b2b_stall_c%0d: got %b want %b", c, stall, (c <= 33)); end
         if (c == 34) begin
            vec_cnt++; if (done !== 1'b1) begin err_cnt++; $display("FAIL b2b_done1: got %b want 1", done); end
            vec_cnt++; if (lo !== 32'd12) begin err_cnt++; $display("FAIL b2b_lo1: got %h want 0000000c", lo); end
            vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL b2b_hi1: got %h want 00000000", hi); end
         end
         next_cycle();
      end
      start = 1'b0; op_a = '0; op_b = '0;
      #1;
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
      cyc = 35;
      while (done !== 1'b1 && cyc < 120) begin
         next_cycle();
         cyc++;
      end
      vec_cnt++; if (cyc != 68) begin err_cnt++; $display("FAIL b2b_done2_cycle: got %0d want 68", cyc); end
      vec_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL b2b_hi2: got %h want ffffffff", hi); end
      vec_cnt++; if (lo !== 32'hFFFF_FFF2) begin err_cnt++; $display("FAIL b2b_lo2: got %h want fffffff2", lo); end
      next_cycle();
   endtask

   task automatic test_flush();
      int pulses;
      // flush in RUN cycle 10
      start = 1'b1; is_signed = 1'b0; op_a = 32'd9; op_b = 32'd9;
      next_cycle();
      start = 1'b0;
      for (int i = 0; i < 9; i++) next_cycle();
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      #1;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL flush_run_busy: got %b want 0", busy); end
      pulses = 0;
      repeat (40) begin
         if (done === 1'b1) pulses++;
         next_cycle();
      end
      vec_cnt++; if (pulses != 0) begin err_cnt++; $display("FAIL flush_run_done_pulses: got %0d want 0", pulses); end
      vec_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL flush_run_hi: got %h want ffffffff", hi); end
      vec_cnt++; if (lo !== 32'hFFFF_FFF2) begin err_cnt++; $display("FAIL flush_run_lo: got %h want fffffff2", lo); end
      // start together with flush in IDLE
      start = 1'b1; flush = 1'b1; op_a = 32'd3; op_b = 32'd3;
      next_cycle();
      start = 1'b0; flush = 1'b0;
      #1;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL flush_idle_busy: got %b want 0", busy); end
      next_cycle();
      // flush during FIX
      start = 1'b1; op_a = 32'd9; op_b = 32'd9;
      next_cycle();
      start = 1'b0;
      for (int i = 0; i < 32; i++) next_cycle();
      vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL flush_fix_busy_before: got %b want 1", busy); end
      flush = 1'b1;
      next_cycle();
      flush = 1'b0;
      #1;
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL flush_fix_done: got %b want 0", done); end
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL flush_fix_busy: got %b want 0", busy); end
      vec_cnt++; if (lo !== 32'hFFFF_FFF2) begin err_cnt++; $display("FAIL flush_fix_lo: got %h want fffffff2", lo); end
      vec_cnt++; if (hi !== 32'hFFFF_FFFF) begin err_cnt++; $display("FAIL flush_fix_hi: got %h want ffffffff", hi); end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      int lat, bcnt;
      logic [W-1:0] h, l;
      start = 1'b1; is_signed = 1'b0; op_a = 32'h0000_FFFF; op_b = 32'h0000_FFFF;
      next_cycle();
      start = 1'b0;
      for (int i = 0; i < 14; i++) next_cycle();
      hilo_read = 1'b1;
      #1;
      vec_cnt++; if (stall !== 1'b1) begin err_cnt++; $display("FAIL rstmid_stall_before: got %b want 1", stall); end
      #2 rst_n = 1'b0;
      #1;
      vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      vec_cnt++; if (stall !== 1'b0) begin err_cnt++; $display("FAIL rstmid_stall: got %b want 0", stall); end
      vec_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rstmid_done: got %b want 0", done); end
      vec_cnt++; if (hi !== 32'h0) begin err_cnt++; $display("FAIL rstmid_hi: got %h want 00000000", hi); end
      vec_cnt++; if (lo !== 32'h0) begin err_cnt++; $display("FAIL rstmid_lo: got %h want 00000000", lo); end
      hilo_read = 1'b0;
      #1 rst_n = 1'b1;
      next_cycle();
      run_op(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, lat, bcnt, h, l);
      vec_cnt++; if (lat != 34) begin err_cnt++; $display("FAIL rstmid_relat: got %0d want 34", lat); end
      vec_cnt++; if (h !== 32'h0) begin err_cnt++; $display("FAIL rstmid_rehi: got %h want 00000000", h); end
      vec_cnt++; if (l !== 32'hFFFE_0001) begin err_cnt++; $display("FAIL rstmid_relo: got %h want fffe0001", l); end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_unsigned_max();
      test_signed();
      test_hilo_interlock();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
